// File: rtl/rw_core_pkg.sv
// Shared RockWave core definitions: machine width, canonical NOP, fetch defaults
// and the {pc, inst} record that moves from Fetch to Decode.
package rw_core_pkg;

   localparam int              XLEN                 = 32;
   localparam logic [XLEN-1:0] INST_NOP             = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam int              DEFAULT_ROM_AW       = 12;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-to-Decode instruction handshake: Fetch is the master, Decode the slave.
interface fetch_ctrl_if;
   import rw_core_pkg::*;

   logic            inst_valid;
   logic [XLEN-1:0] inst_data;
   logic [XLEN-1:0] inst_pc;
   logic            inst_ready;

   modport master (output inst_valid, inst_data, inst_pc, input inst_ready);
   modport slave  (input inst_valid, inst_data, inst_pc, output inst_ready);

endinterface

// File: rtl/fetch_buf.sv
// DEPTH-entry shifting FIFO of fetched {pc, inst}; entry 0 is always the head,
// so the Decode-facing outputs come straight from flops.
module fetch_buf
   import rw_core_pkg::*;
#(
   parameter int              DEPTH    = 2,
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_VECTOR,
   localparam int             CW       = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output logic [CW-1:0] count,
   output logic         head_valid,
   output fetch_entry_t head
);

   fetch_entry_t  ent_q [DEPTH];
   fetch_entry_t  ent_d [DEPTH];
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] base;
   logic          valid_q, valid_d;
   logic          pop_eff;

   always_comb begin
      ent_d   = ent_q;
      count_d = count_q;
      pop_eff = pop & valid_q;
      base    = count_q - CW'(pop_eff);
      if (pop_eff) begin
         for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i + 1];
      end
      // A flush still honours the pop above: Decode keeps a head it handshook.
      if (flush) begin
         count_d = '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (push && base == CW'(i)) ent_d[i] = push_entry;
         end
         count_d = base + CW'(push);
      end
      valid_d = (count_d != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '{pc: RESET_PC, inst: INST_NOP};
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         ent_q   <= ent_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   assign count      = count_q;
   assign head_valid = valid_q;
   assign head       = ent_q[0];

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !flush && !pop_eff && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_ctrl.sv
// RockWave Fetch stage: owns the PC, drives the synchronous ROM address and
// queues returned words (tagged with their PC) for Decode.
module fetch_ctrl
   import rw_core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int              ROM_AW       = DEFAULT_ROM_AW,
   parameter int              DEPTH        = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [XLEN-1:0]   rom_q,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   fetch_ctrl_if.master      dec
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = CW + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic            inflight_q, inflight_d;
   logic            pop, issue, push;
   logic [CW-1:0]   count;
   logic [OW-1:0]   occupancy;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   assign pop = dec.inst_valid & dec.inst_ready;

   // Slots committed after this edge; counting the pop lets a full-rate stream issue.
   assign occupancy  = OW'(count) + OW'(inflight_q) - OW'(pop);
   assign issue      = ~redirect_valid & (occupancy < OW'(DEPTH));
   assign push       = inflight_q & ~redirect_valid;
   assign push_entry = '{pc: inflight_pc_q, inst: rom_q};
   assign rom_addr   = fetch_pc_q[ROM_AW+1:2];

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~XLEN'(3);
      end else if (issue) begin
         inflight_d    = 1'b1;
         inflight_pc_d = fetch_pc_q;
         fetch_pc_d    = fetch_pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_VECTOR;
         inflight_q    <= 1'b0;
         inflight_pc_q <= RESET_VECTOR;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   fetch_buf #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_VECTOR)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect_valid),
      .count      (count),
      .head_valid (dec.inst_valid),
      .head       (head)
   );

   assign dec.inst_data = head.inst;
   assign dec.inst_pc   = head.pc;

endmodule
